// File: rtl/switch_sequencer.sv
// rtl/switch_sequencer.sv - steps the photonic switch bank through a programmed pattern table
// Each pattern change is followed by a guard interval, then a dwell hold, both counted in en_tick units.
module switch_sequencer #(
    parameter int              N_SLOTS  = 8,
    parameter int              SW_W     = 4,
    parameter int              DWELL_W  = 16,
    parameter int              GUARD    = 2,
    parameter logic [SW_W-1:0] SAFE_PAT = '0,
    localparam int             SLOT_W   = $clog2(N_SLOTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_tick,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [SLOT_W:0]    num_slots,
    input  logic               cfg_we,
    input  logic [SLOT_W-1:0]  cfg_addr,
    input  logic [SW_W-1:0]    cfg_pat,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [SW_W-1:0]    sw_out,
    output logic [SLOT_W-1:0]  slot,
    output logic               busy,
    output logic               valid,
    output logic               slot_strobe,
    output logic               done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;

    localparam logic [DWELL_W-1:0] GUARD_TICKS = DWELL_W'(GUARD);
    localparam logic [SLOT_W-1:0]  LAST_MAX    = SLOT_W'(N_SLOTS - 1);
    localparam logic [SLOT_W:0]    NUM_MAX     = (SLOT_W + 1)'(N_SLOTS);

    // Table storage is deliberately left out of reset.
    logic [SW_W-1:0]    pat_mem   [N_SLOTS];
    logic [DWELL_W-1:0] dwell_mem [N_SLOTS];

    logic [1:0]         state_q,  state_d;
    logic [SW_W-1:0]    sw_out_q, sw_out_d;
    logic [SLOT_W-1:0]  slot_q,   slot_d;
    logic [SLOT_W-1:0]  last_q,   last_d;
    logic               busy_q,   busy_d;
    logic               valid_q,  valid_d;
    logic               strobe_q, strobe_d;
    logic               done_q,   done_d;
    logic               entry_q,  entry_d;
    logic [DWELL_W-1:0] cnt_q,    cnt_d;

    logic [DWELL_W-1:0] cnt_inc;
    logic [DWELL_W-1:0] dwell_cur;
    logic [DWELL_W-1:0] dwell_tgt;
    logic [SLOT_W-1:0]  nxt_slot;
    logic [SLOT_W-1:0]  last_start;
    logic               tick_cnt;

    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q) begin
            pat_mem[cfg_addr]   <= cfg_pat;
            dwell_mem[cfg_addr] <= cfg_dwell;
        end
    end

    always_comb begin
        cnt_inc   = cnt_q + 1'b1;
        dwell_cur = dwell_mem[slot_q];
        dwell_tgt = (dwell_cur == '0) ? DWELL_W'(1) : dwell_cur;
        nxt_slot  = (slot_q == last_q) ? '0 : slot_q + 1'b1;
        // The tick landing in the first cycle of a state is not counted.
        tick_cnt  = en_tick && !entry_q;
        if ((num_slots == '0) || (num_slots > NUM_MAX)) begin
            last_start = LAST_MAX;
        end else begin
            last_start = SLOT_W'(num_slots - 1'b1);
        end
    end

    always_comb begin
        state_d  = state_q;
        sw_out_d = sw_out_q;
        slot_d   = slot_q;
        last_d   = last_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        entry_d  = 1'b0;
        cnt_d    = cnt_q;

        if (stop) begin
            state_d  = ST_IDLE;
            sw_out_d = SAFE_PAT;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_GUARD;
                        sw_out_d = pat_mem[0];
                        slot_d   = '0;
                        last_d   = last_start;
                        busy_d   = 1'b1;
                        strobe_d = 1'b1;
                        entry_d  = 1'b1;
                        cnt_d    = '0;
                    end
                end
                ST_GUARD: begin
                    if (tick_cnt) begin
                        if (cnt_inc == GUARD_TICKS) begin
                            state_d = ST_DWELL;
                            valid_d = 1'b1;
                            entry_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_DWELL: begin
                    if (tick_cnt) begin
                        if (cnt_inc >= dwell_tgt) begin
                            cnt_d   = '0;
                            valid_d = 1'b0;
                            if ((slot_q != last_q) || loop_en) begin
                                state_d  = ST_GUARD;
                                slot_d   = nxt_slot;
                                sw_out_d = pat_mem[nxt_slot];
                                strobe_d = 1'b1;
                                entry_d  = 1'b1;
                            end else begin
                                state_d  = ST_IDLE;
                                sw_out_d = SAFE_PAT;
                                busy_d   = 1'b0;
                                done_d   = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sw_out_d = SAFE_PAT;
                    busy_d   = 1'b0;
                    valid_d  = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sw_out_q <= SAFE_PAT;
            slot_q   <= '0;
            last_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            entry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sw_out_q <= sw_out_d;
            slot_q   <= slot_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_out      = sw_out_q;
    assign slot        = slot_q;
    assign busy        = busy_q;
    assign valid       = valid_q;
    assign slot_strobe = strobe_q;
    assign done        = done_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// tb/tb_switch_sequencer.sv - scoreboard bench for switch_sequencer
module tb_switch_sequencer;

    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [3:0]  num_slots = 4'd0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [3:0]  cfg_pat = 4'd0;
    logic [15:0] cfg_dwell = 16'd0;
    logic [3:0]  sw_out;
    logic [2:0]  slot;
    logic        busy;
    logic        valid;
    logic        slot_strobe;
    logic        done;

    switch_sequencer #(
        .N_SLOTS (8),
        .SW_W    (4),
        .DWELL_W (16),
        .GUARD   (GUARD),
        .SAFE_PAT(4'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_tick    (en_tick),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .num_slots  (num_slots),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_pat    (cfg_pat),
        .cfg_dwell  (cfg_dwell),
        .sw_out     (sw_out),
        .slot       (slot),
        .busy       (busy),
        .valid      (valid),
        .slot_strobe(slot_strobe),
        .done       (done)
    );

    typedef struct packed {
        logic [3:0]  pat;
        logic [2:0]  slot;
        logic [15:0] dwell;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   g_cnt = 0;
    int   d_cnt = 0;
    logic prev_valid = 1'b0;
    logic abort_pending = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // en_tick: one cycle in eight, like the 1 MHz enable from the divider chain.
    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #1;
            en_tick = (div == 7);
            div = (div + 1) % 8;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (!valid && prev_valid) begin
                if (abort_pending) abort_pending = 1'b0;
                else check("dwell_ticks", d_cnt, cur.dwell);
            end
            if (slot_strobe) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", slot_strobe, 0);
                end else begin
                    cur = sb.pop_front();
                    check("strobe_pat", sw_out, cur.pat);
                    check("strobe_slot", slot, cur.slot);
                    check("strobe_busy", busy, 1);
                    check("strobe_valid", valid, 0);
                end
                g_cnt = 0;
            end else if (busy && !valid) begin
                g_cnt += en_tick;
            end
            if (valid && !prev_valid) begin
                check("guard_ticks", g_cnt, GUARD);
                check("dwell_pat", sw_out, cur.pat);
                d_cnt = 0;
            end else if (valid) begin
                d_cnt += en_tick;
            end
            if (done) begin
                done_cnt++;
                check("done_sw", sw_out, 0);
                check("done_busy", busy, 0);
                check("done_valid", valid, 0);
            end
            prev_valid = valid;
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] p, input logic [15:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_pat = p; cfg_dwell = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [3:0] p, input logic [2:0] s, input logic [15:0] d);
        exp_t e;
        e.pat = p; e.slot = s; e.dwell = d;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_idle_sw"}, sw_out, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int d0;
        int n;
        logic [3:0] pats [3];
        logic [15:0] dwl [3];
        pats[0] = 4'h1; pats[1] = 4'h2; pats[2] = 4'h4;
        dwl[0] = 16'd3; dwl[1] = 16'd5; dwl[2] = 16'd2;

        repeat (4) @(posedge clk);
        #1 reset = 1'b0;

        // 1: idle after reset
        @(negedge clk);
        check("rst_slot", slot, 0);
        check("rst_strobe", slot_strobe, 0);
        check("rst_done", done, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_sw", sw_out, 0);
            check("idle_busy", busy, 0);
            check("idle_valid", valid, 0);
        end

        // 2: single pass of three slots
        for (int i = 0; i < 3; i++) cfg_write(3'(i), pats[i], dwl[i]);
        num_slots = 4'd3; loop_en = 1'b0;
        for (int i = 0; i < 3; i++) push(pats[i], 3'(i), dwl[i]);
        d0 = done_cnt;
        pulse_start();
        wait_done("pass", d0);

        // 3: loop, then clear loop_en during the second pass
        loop_en = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) push(pats[i], 3'(i), dwl[i]);
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (sb.size() > 2 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("loop_wrapped", sb.size(), 2);
        @(posedge clk); #1 loop_en = 1'b0;
        wait_done("loop", d0);

        // 4: stop in dwell of slot 1, then restart
        push(pats[0], 3'd0, dwl[0]);
        push(pats[1], 3'd1, dwl[1]);
        d0 = done_cnt;
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(valid && slot == 3'd1) && n < 4000);
        check("stop_reached", {valid, slot}, {1'b1, 3'd1});
        stop = 1'b1; abort_pending = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        check("stop_sw", sw_out, 0);
        check("stop_busy", busy, 0);
        check("stop_valid", valid, 0);
        repeat (60) @(negedge clk);
        check("stop_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 3; i++) push(pats[i], 3'(i), dwl[i]);
        pulse_start();
        wait_done("restart", d0);

        // 5: dwell 0 acts as 1, num_slots 0 visits all eight slots
        for (int i = 0; i < 8; i++) begin
            cfg_write(3'(i), 4'(i + 1), (i == 3) ? 16'd0 : ((i == 5) ? 16'd2 : 16'd1));
            push(4'(i + 1), 3'(i), (i == 5) ? 16'd2 : 16'd1);
        end
        num_slots = 4'd0;
        d0 = done_cnt;
        pulse_start();
        wait_done("all", d0);

        // 6: config write and start while busy are dropped
        num_slots = 4'd2;
        push(4'h1, 3'd0, 16'd1);
        push(4'h2, 3'd1, 16'd1);
        d0 = done_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        check("busy_mid", busy, 1);
        cfg_write(3'd0, 4'hF, 16'd7);
        pulse_start();
        wait_done("busy1", d0);
        push(4'h1, 3'd0, 16'd1);
        push(4'h2, 3'd1, 16'd1);
        d0 = done_cnt;
        pulse_start();
        wait_done("busy2", d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
